// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receiver control FSM.
// Recovers one bit per Prescale clocks and assembles LSB-first frames of
// start, DATA_WIDTH data bits, optional parity and stop. It strobes
// data_valid on a good frame and flags start glitches, stop errors and
// parity errors.
// Build option: define RX_MAJORITY_VOTE_EN to recover each bit as the
// 2-of-3 vote of three mid-bit samples instead of a single sample.
// Frame timing is the same in both builds.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle; waiting for a low level to start a frame
// START  | timing the start bit; rejects it if it reads high
// DATA   | shifting in DATA_WIDTH data bits, LSB first
// PARITY | parity bit; strobes the external checker, latches its result
// STOP   | stop bit; reports the frame result, may chain into START
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [5:0]            Prescale,
    input  logic                  par_err,
    output logic                  par_chk_en,
    output logic                  sampled_bit,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  strt_glitch,
    output logic                  stp_err,
    output logic                  par_err_flg
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] good_q, good_d;
    logic                  par_flag_q, par_flag_d;
    logic [5:0]            presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  sampled_q, sampled_d;
`ifdef RX_MAJORITY_VOTE_EN
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
`endif

    logic [5:0] presc_legal;
    logic [5:0] half;
    logic [5:0] last;
    logic       decide;

    // Bit-period bookkeeping: half-bit sample point and end-of-bit decision.
    always_comb begin
        presc_legal = ((Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32))
                      ? Prescale : 6'd8;
        half   = presc_q >> 1;
        last   = presc_q - 6'd1;
        decide = (state_q != IDLE) && (edge_cnt_q == last);
    end

    // Next-state logic for the frame FSM, counters and data registers.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        good_d     = good_q;
        par_flag_d = par_flag_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        sampled_d  = sampled_q;
`ifdef RX_MAJORITY_VOTE_EN
        s0_d       = s0_q;
        s1_d       = s1_q;
`endif

        if (state_q != IDLE) begin
            edge_cnt_d = decide ? 6'd0 : edge_cnt_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = 6'd0;
                if (!RX_IN) begin
                    state_d    = START;
                    presc_d    = presc_legal;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                if (decide) begin
                    if (sampled_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {sampled_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_flag_d = par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (sampled_q && !par_flag_q) begin
                        good_d = shift_q;
                    end
                    // A low line right at the stop decision is the next start bit.
                    if (!RX_IN) begin
                        state_d    = START;
                        par_flag_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef RX_MAJORITY_VOTE_EN
        if (state_q != IDLE) begin
            if (edge_cnt_q == half - 6'd1) s0_d = RX_IN;
            if (edge_cnt_q == half)        s1_d = RX_IN;
            if (edge_cnt_q == half + 6'd1) begin
                sampled_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
            end
        end
`else
        if ((state_q != IDLE) && (edge_cnt_q == half)) begin
            sampled_d = RX_IN;
        end
`endif
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            good_q     <= '0;
            par_flag_q <= 1'b0;
            presc_q    <= 6'd8;
            par_en_q   <= 1'b0;
            sampled_q  <= 1'b1;
`ifdef RX_MAJORITY_VOTE_EN
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            good_q     <= good_d;
            par_flag_q <= par_flag_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            sampled_q  <= sampled_d;
`ifdef RX_MAJORITY_VOTE_EN
            s0_q       <= s0_d;
            s1_q       <= s1_d;
`endif
        end
    end

    // Strobes are decoded from registered state so they land in the decision cycle.
    always_comb begin
        sampled_bit = sampled_q;
        par_chk_en  = (state_q == PARITY) && decide;
        strt_glitch = (state_q == START) && decide && sampled_q;
        stp_err     = (state_q == STOP) && decide && !sampled_q;
        par_err_flg = (state_q == STOP) && decide && par_flag_q;
        data_valid  = (state_q == STOP) && decide && sampled_q && !par_flag_q;
        // The assembled byte is visible while the parity checker needs it and
        // through the stop bit; otherwise the last good byte is shown.
        P_DATA      = ((state_q == PARITY) || (state_q == STOP)) ? shift_q : good_q;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed, table-driven bench for uart_rx_fsm.
// The line is driven one clock ahead of the receiver's bit boundaries:
// the receiver enters START on the edge after the line drops. Latency is
// measured inclusively from the first START cycle, which equals the
// number of cycles from the line drop to the data_valid cycle.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       par_err;
    logic       par_chk_en;
    logic       sampled_bit;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       strt_glitch;
    logic       stp_err;
    logic       par_err_flg;

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .par_err     (par_err),
        .par_chk_en  (par_chk_en),
        .sampled_bit (sampled_bit),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .strt_glitch (strt_glitch),
        .stp_err     (stp_err),
        .par_err_flg (par_err_flg)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int         n_dv = 0, n_stp = 0, n_pf = 0, n_pchk = 0, n_gl = 0;
    int         dv_cyc = 0, dv_prev_cyc = 0;
    logic [7:0] pchk_data = 8'h00;

    always @(negedge CLK) begin
        if (data_valid) begin
            n_dv        = n_dv + 1;
            dv_prev_cyc = dv_cyc;
            dv_cyc      = cyc;
        end
        if (stp_err)     n_stp = n_stp + 1;
        if (par_err_flg) n_pf  = n_pf + 1;
        if (strt_glitch) n_gl  = n_gl + 1;
        if (par_chk_en) begin
            n_pchk    = n_pchk + 1;
            pchk_data = P_DATA;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input int blen, input logic pe, input logic [7:0] d,
                              input logic stopb, input logic chg, output int start_cyc);
        start_cyc = cyc;
        drive(1'b0, blen);
        if (chg) begin
            Prescale = 6'd32;
            PAR_EN   = ~PAR_EN;
        end
        for (int i = 0; i < 8; i++) drive(d[i], blen);
        if (pe) drive(^d, blen);
        drive(stopb, blen);
    endtask

    typedef struct {
        logic [5:0] presc;
        int         blen;
        logic       pe;
        logic [7:0] data;
        logic       stopb;
        logic       perr;
        logic       chg;
        int         e_dv;
        int         e_stp;
        int         e_pf;
        int         e_pchk;
        logic [7:0] e_pdata;
        int         e_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int b_dv, b_stp, b_pf, b_pchk, b_gl, st;

        //           presc blen pe  data   stp  perr chg  dv stp pf pchk pdata  lat
        vecs[0] = '{6'd8,  8,  1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 8'hA5, 80};
        vecs[1] = '{6'd16, 16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1, 8'h3C, 176};
        vecs[2] = '{6'd8,  8,  1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 8'h3C, 0};
        vecs[3] = '{6'd32, 32, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 8'h0F, 320};
        vecs[4] = '{6'd8,  8,  1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 0, 0, 1, 1, 8'h0F, 0};
        vecs[5] = '{6'd20, 8,  1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 8'hC3, 80};
        vecs[6] = '{6'd16, 16, 1'b1, 8'h6E, 1'b0, 1'b1, 1'b0, 0, 1, 1, 1, 8'hC3, 0};
        vecs[7] = '{6'd8,  8,  1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 8'h5A, 80};

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; par_err = 1'b0; Prescale = 6'd8;
        repeat (3) @(posedge CLK);
        #1;
        check("reset P_DATA", P_DATA, 8'h00);
        check("reset sampled_bit", sampled_bit, 1);
        check("reset strobes", {data_valid, strt_glitch, stp_err, par_err_flg, par_chk_en}, 0);
        RST = 1'b0;
        drive(1'b1, 4);

        for (int v = 0; v < 8; v++) begin
            Prescale = vecs[v].presc;
            PAR_EN   = vecs[v].pe;
            par_err  = vecs[v].perr;
            b_dv = n_dv; b_stp = n_stp; b_pf = n_pf; b_pchk = n_pchk; b_gl = n_gl;
            send_frame(vecs[v].blen, vecs[v].pe, vecs[v].data, vecs[v].stopb, vecs[v].chg, st);
            Prescale = vecs[v].presc;
            PAR_EN   = vecs[v].pe;
            drive(1'b1, 6);
            check($sformatf("v%0d data_valid count", v), n_dv - b_dv, vecs[v].e_dv);
            check($sformatf("v%0d stp_err count", v), n_stp - b_stp, vecs[v].e_stp);
            check($sformatf("v%0d par_err_flg count", v), n_pf - b_pf, vecs[v].e_pf);
            check($sformatf("v%0d par_chk_en count", v), n_pchk - b_pchk, vecs[v].e_pchk);
            check($sformatf("v%0d strt_glitch count", v), n_gl - b_gl, 0);
            check($sformatf("v%0d P_DATA", v), P_DATA, vecs[v].e_pdata);
            if (vecs[v].e_dv != 0)
                check($sformatf("v%0d latency", v), dv_cyc - st, vecs[v].e_lat);
            if (vecs[v].e_pchk != 0)
                check($sformatf("v%0d P_DATA at parity", v), pchk_data, vecs[v].data);
        end
        par_err = 1'b0;
        PAR_EN  = 1'b0;
        Prescale = 6'd8;

        // Short low pulse on an idle line must be rejected as a start glitch.
        b_dv = n_dv; b_gl = n_gl;
        drive(1'b0, 2);
        drive(1'b1, 20);
        check("glitch strt_glitch count", n_gl - b_gl, 1);
        check("glitch data_valid count", n_dv - b_dv, 0);
        check("glitch P_DATA held", P_DATA, 8'h5A);

        // Back-to-back frames with no idle gap.
        b_dv = n_dv; b_stp = n_stp;
        send_frame(8, 1'b0, 8'h12, 1'b1, 1'b0, st);
        send_frame(8, 1'b0, 8'h34, 1'b1, 1'b0, st);
        drive(1'b1, 6);
        check("b2b data_valid count", n_dv - b_dv, 2);
        check("b2b spacing", dv_cyc - dv_prev_cyc, 80);
        check("b2b stp_err count", n_stp - b_stp, 0);
        check("b2b P_DATA", P_DATA, 8'h34);

        // Reset in the middle of bit 4 of a frame, then a clean frame.
        b_dv = n_dv; b_stp = n_stp; b_pf = n_pf; b_gl = n_gl;
        begin
            logic [7:0] d81;
            d81 = 8'h81;
            drive(1'b0, 8);
            for (int i = 0; i < 4; i++) drive(d81[i], 8);
            drive(d81[4], 3);
        end
        RST = 1'b1;
        RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst P_DATA", P_DATA, 8'h00);
        check("midrst sampled_bit", sampled_bit, 1);
        drive(1'b1, 12);
        check("midrst no strobes", (n_dv - b_dv) + (n_stp - b_stp) + (n_pf - b_pf) + (n_gl - b_gl), 0);
        b_dv = n_dv;
        send_frame(8, 1'b0, 8'h81, 1'b1, 1'b0, st);
        drive(1'b1, 6);
        check("after rst data_valid count", n_dv - b_dv, 1);
        check("after rst latency", dv_cyc - st, 80);
        check("after rst P_DATA", P_DATA, 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
